// File: rtl/byte_inc_pkg.sv
// Shared types and byte-lane helpers for the byte increment engines.
// Word/lane widths here set the defaults of the engine's parameters.
package byte_inc_pkg;

  localparam int WORD_BITS  = 64;
  localparam int WADDR_BITS = 10;
  localparam int LANES      = WORD_BITS / 8;
  localparam int OFS_W      = $clog2(LANES);

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [LANES-1:0]     be_t;
  typedef logic [OFS_W-1:0]     ofs_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic word_t inc_bytes(input word_t w, input logic sat);
    word_t r;
    for (int i = 0; i < LANES; i++) begin
      if (sat && (w[i*8 +: 8] == 8'hFF)) r[i*8 +: 8] = 8'hFF;
      else                               r[i*8 +: 8] = w[i*8 +: 8] + 8'd1;
    end
    return r;
  endfunction

  // Lanes at or above the window start offset.
  function automatic be_t first_mask(input ofs_t ofs);
    be_t ones;
    ones = '1;
    return ones << ofs;
  endfunction

  // Lanes at or below the window end offset.
  function automatic be_t last_mask(input ofs_t ofs);
    be_t ones;
    ones = '1;
    return ones >> (ofs_t'(LANES - 1) - ofs);
  endfunction

endpackage

// File: rtl/byte_inc_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on dout whenever !empty.
// DEPTH must be a power of two.
module byte_inc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/byte_inc_pipelined.sv
// Avalon-MM read-modify-write engine: increments every byte of [base, base+length)
// with several reads in flight, decoupled from the writer by a response FIFO.
module byte_inc_pipelined
  import byte_inc_pkg::*;
#(
  parameter int DATA_WIDTH      = WORD_BITS,
  parameter int ADDR_WIDTH      = WADDR_BITS,
  parameter int BYTE_CNT        = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [ADDR_WIDTH+OFS_W-1:0] base_addr_i,
  input  logic [ADDR_WIDTH+OFS_W-1:0] length_i,
  input  logic                        run_i,
  output logic                        waitrequest_o,
  output logic [ADDR_WIDTH-1:0]       amm_rd_address_o,
  output logic                        amm_rd_read_o,
  input  logic                        amm_rd_waitrequest_i,
  input  logic [DATA_WIDTH-1:0]       amm_rd_readdata_i,
  input  logic                        amm_rd_readdatavalid_i,
  output logic [ADDR_WIDTH-1:0]       amm_wr_address_o,
  output logic                        amm_wr_write_o,
  output logic [DATA_WIDTH-1:0]       amm_wr_writedata_o,
  output logic [BYTE_CNT-1:0]         amm_wr_byteenable_o,
  input  logic                        amm_wr_waitrequest_i
);

  localparam int BA_W = ADDR_WIDTH + OFS_W;
  localparam int NW   = ADDR_WIDTH + 1;
  localparam int CW   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FW   = DATA_WIDTH + ADDR_WIDTH + BYTE_CNT;

  state_t                state_q, state_d;
  logic [NW-1:0]         nwords_q;
  ofs_t                  first_ofs_q, last_ofs_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_read_q;
  logic [NW-1:0]         rd_left_q;
  logic [CW-1:0]         out_cnt_q;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic [NW-1:0]         rsp_idx_q;
  logic [NW-1:0]         wr_left_q;
  logic                  wr_write_p1;
  logic [ADDR_WIDTH-1:0] wr_addr_p1;
  logic [DATA_WIDTH-1:0] wr_data_p1;
  logic [BYTE_CNT-1:0]   wr_be_p1;

  logic [BA_W-1:0]       end_byte;
  logic [ADDR_WIDTH-1:0] first_word, last_word, span;
  logic                  start_ok;
  logic                  rd_acc, wr_acc, last_wr;
  logic                  push_p0, load_p1;
  logic [CW-1:0]         out_nxt;
  logic [NW-1:0]         rd_left_nxt;
  be_t                   rsp_be_p0;
  logic [FW-1:0]         fifo_din, fifo_dout;
  logic                  fifo_empty, fifo_full;

  // Window decode; addresses wrap modulo the byte address space.
  assign end_byte   = base_addr_i + length_i - BA_W'(1);
  assign first_word = base_addr_i[BA_W-1:OFS_W];
  assign last_word  = end_byte[BA_W-1:OFS_W];
  assign span       = last_word - first_word;
  assign start_ok   = (state_q == ST_IDLE) && run_i && (length_i != '0);

  assign rd_acc      = rd_read_q && !amm_rd_waitrequest_i;
  assign wr_acc      = wr_write_p1 && !amm_wr_waitrequest_i;
  assign last_wr     = wr_acc && (wr_left_q == NW'(1));
  assign out_nxt     = out_cnt_q + CW'(rd_acc) - CW'(wr_acc);
  assign rd_left_nxt = rd_left_q - NW'(rd_acc);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN:  if (last_wr)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: tag each in-order response with its word address and lane mask.
  assign push_p0   = (state_q == ST_RUN) && amm_rd_readdatavalid_i;
  assign rsp_be_p0 = ((rsp_idx_q == '0) ? first_mask(first_ofs_q) : '1) &
                     ((rsp_idx_q == nwords_q - NW'(1)) ? last_mask(last_ofs_q) : '1);
  assign fifo_din  = {amm_rd_readdata_i, rsp_addr_q, rsp_be_p0};

  byte_inc_fifo #(
    .WIDTH(FW),
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk  (clk),
    .srst (srst),
    .push (push_p0),
    .pop  (load_p1),
    .din  (fifo_din),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Stage p1: writer register refills whenever it is empty or just accepted.
  assign load_p1 = (state_q == ST_RUN) && !fifo_empty && (!wr_write_p1 || wr_acc);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      nwords_q    <= '0;
      first_ofs_q <= '0;
      last_ofs_q  <= '0;
      rd_addr_q   <= '0;
      rd_read_q   <= 1'b0;
      rd_left_q   <= '0;
      out_cnt_q   <= '0;
      rsp_addr_q  <= '0;
      rsp_idx_q   <= '0;
      wr_left_q   <= '0;
      wr_write_p1 <= 1'b0;
      wr_addr_p1  <= '0;
      wr_data_p1  <= '0;
      wr_be_p1    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        nwords_q    <= {1'b0, span} + NW'(1);
        first_ofs_q <= base_addr_i[OFS_W-1:0];
        last_ofs_q  <= end_byte[OFS_W-1:0];
        rd_addr_q   <= first_word;
        rd_read_q   <= 1'b1;
        rd_left_q   <= {1'b0, span} + NW'(1);
        out_cnt_q   <= '0;
        rsp_addr_q  <= first_word;
        rsp_idx_q   <= '0;
        wr_left_q   <= {1'b0, span} + NW'(1);
      end else if (state_q == ST_RUN) begin
        out_cnt_q <= out_nxt;
        rd_left_q <= rd_left_nxt;
        if (rd_acc) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
        // A stalled request is held; otherwise reissue only with credit left.
        if (rd_read_q && amm_rd_waitrequest_i) rd_read_q <= 1'b1;
        else rd_read_q <= (rd_left_nxt != '0) && (out_nxt < CW'(MAX_OUTSTANDING)) && !fifo_full;
        if (push_p0) begin
          rsp_addr_q <= rsp_addr_q + ADDR_WIDTH'(1);
          rsp_idx_q  <= rsp_idx_q + NW'(1);
        end
        if (wr_acc) wr_left_q <= wr_left_q - NW'(1);
        if (load_p1) begin
          wr_write_p1 <= 1'b1;
          wr_addr_p1  <= fifo_dout[BYTE_CNT +: ADDR_WIDTH];
          wr_data_p1  <= inc_bytes(fifo_dout[FW-1 -: DATA_WIDTH], SATURATE);
          wr_be_p1    <= fifo_dout[BYTE_CNT-1:0];
        end else if (wr_acc) begin
          wr_write_p1 <= 1'b0;
        end
      end
    end
  end

  assign waitrequest_o       = (state_q == ST_RUN);
  assign amm_rd_address_o    = rd_addr_q;
  assign amm_rd_read_o       = rd_read_q;
  assign amm_wr_address_o    = wr_addr_p1;
  assign amm_wr_write_o      = wr_write_p1;
  assign amm_wr_writedata_o  = wr_data_p1;
  assign amm_wr_byteenable_o = wr_be_p1;

endmodule

// File: tb/tb_byte_inc_pipelined.sv
// Bench for byte_inc_pipelined: byte-array memory slave with optional random
// stalls/latency, a byte-level window model, vector table and corner sequences.
module tb_byte_inc_pipelined;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BC = 8;
  localparam int BA = 13;
  localparam int NB = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst;
  logic [BA-1:0] base_addr, length, base1, len1;
  logic          run, run1;
  logic          waitreq, waitreq1;
  logic [AW-1:0] rd_addr, rd_addr1, wr_addr, wr_addr1;
  logic          rd_read, rd_read1, rd_wait, rd_wait1, rd_valid, rd_valid1;
  logic [DW-1:0] rd_data, rd_data1, wr_data, wr_data1;
  logic          wr_write, wr_write1, wr_wait, wr_wait1;
  logic [BC-1:0] wr_be, wr_be1;

  byte_inc_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC),
                       .MAX_OUTSTANDING(4), .SATURATE(1'b0)) dut (
    .clk(clk), .srst(srst), .base_addr_i(base_addr), .length_i(length), .run_i(run),
    .waitrequest_o(waitreq), .amm_rd_address_o(rd_addr), .amm_rd_read_o(rd_read),
    .amm_rd_waitrequest_i(rd_wait), .amm_rd_readdata_i(rd_data),
    .amm_rd_readdatavalid_i(rd_valid), .amm_wr_address_o(wr_addr),
    .amm_wr_write_o(wr_write), .amm_wr_writedata_o(wr_data),
    .amm_wr_byteenable_o(wr_be), .amm_wr_waitrequest_i(wr_wait));

  byte_inc_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_CNT(BC),
                       .MAX_OUTSTANDING(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .srst(srst), .base_addr_i(base1), .length_i(len1), .run_i(run1),
    .waitrequest_o(waitreq1), .amm_rd_address_o(rd_addr1), .amm_rd_read_o(rd_read1),
    .amm_rd_waitrequest_i(rd_wait1), .amm_rd_readdata_i(rd_data1),
    .amm_rd_readdatavalid_i(rd_valid1), .amm_wr_address_o(wr_addr1),
    .amm_wr_write_o(wr_write1), .amm_wr_writedata_o(wr_data1),
    .amm_wr_byteenable_o(wr_be1), .amm_wr_waitrequest_i(wr_wait1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] mem     [NB];
  logic [7:0] exp_mem [NB];
  logic [7:0] snap    [NB];

  typedef struct { logic [63:0] data; int due; } pend_t;
  typedef struct { int addr; logic [7:0] be; } wlog_t;
  pend_t pend[$];
  wlog_t wlog[$];

  int cyc = 0;
  bit rnd_mode = 1'b0;
  int fixed_lat = 0;
  bit forbid_wr = 1'b0;
  int cur_base = 0, cur_len = 0;
  int rd_cnt = 0, wr_cnt = 0, max_out = 0;
  int n_wr1 = 0;

  function automatic logic [7:0] inc8(input logic [7:0] b, input bit sat);
    return (sat && b == 8'hFF) ? 8'hFF : b + 8'd1;
  endfunction

  function automatic bit in_win(input int b);
    return ((b - cur_base + NB) % NB) < cur_len;
  endfunction

  function automatic logic [63:0] get_word(input int a);
    logic [63:0] w;
    for (int j = 0; j < BC; j++) w[j*8 +: 8] = mem[(a*BC + j) % NB];
    return w;
  endfunction

  // Memory slave for the wrapping instance; acts just after each falling edge.
  initial begin
    rd_wait = 1'b0; rd_valid = 1'b0; rd_data = '0; wr_wait = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rd_valid = 1'b1;
        rd_data  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        rd_valid = 1'b0;
      end
      rd_wait = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
      wr_wait = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (rd_read && !rd_wait && !srst) begin
        pend_t p;
        p.data = get_word(int'(rd_addr));
        p.due  = cyc + 1 + (rnd_mode ? int'($urandom_range(0, 7)) : fixed_lat);
        pend.push_back(p);
        rd_cnt++;
        if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
      end
      if (wr_write && !wr_wait && !srst) begin
        wr_cnt++;
        if (forbid_wr) begin
          check("write_after_reset", wr_write, 1'b0);
        end else begin
          logic [7:0]  ebe;
          logic [63:0] emask, eword;
          wlog_t       w;
          for (int j = 0; j < BC; j++) begin
            ebe[j]           = in_win(int'(wr_addr)*BC + j);
            emask[j*8 +: 8]  = {8{wr_be[j]}};
            eword[j*8 +: 8]  = exp_mem[int'(wr_addr)*BC + j];
          end
          check("wr_byteenable", wr_be, ebe);
          check("wr_data", wr_data & emask, eword & emask);
          for (int j = 0; j < BC; j++)
            if (wr_be[j]) mem[int'(wr_addr)*BC + j] = wr_data[j*8 +: 8];
          w.addr = int'(wr_addr);
          w.be   = wr_be;
          wlog.push_back(w);
        end
      end
    end
  end

  // All-0xFF slave for the saturating instance, zero wait, one-cycle latency.
  initial begin
    bit p1;
    p1 = 1'b0;
    rd_valid1 = 1'b0; rd_data1 = {DW{1'b1}}; rd_wait1 = 1'b0; wr_wait1 = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      rd_valid1 = p1;
      p1 = rd_read1 && !srst;
      if (wr_write1 && !srst) begin
        n_wr1++;
        check("sat_wr_data", wr_data1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sat_wr_be", wr_be1, 8'hFF);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_run(input int b, input int l, input bit poke);
    int n, nbad, nw;
    cur_base = b; cur_len = l;
    rd_cnt = 0; wr_cnt = 0; max_out = 0;
    wlog.delete();
    for (int i = 0; i < NB; i++) exp_mem[i] = mem[i];
    for (int k = 0; k < l; k++) exp_mem[(b + k) % NB] = inc8(mem[(b + k) % NB], 1'b0);
    @(negedge clk);
    base_addr = BA'(b); length = BA'(l); run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("busy_after_start", waitreq, 1'b1);
    if (poke) begin
      base_addr = BA'(200); length = BA'(40); run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check("busy_ignores_run", waitreq, 1'b1);
    end
    n = 0;
    while (waitreq && n < 5000) begin @(negedge clk); n++; end
    check("run_completes", waitreq, 1'b0);
    nbad = 0;
    for (int i = 0; i < NB; i++) if (mem[i] !== exp_mem[i]) nbad++;
    check("mem_final", nbad, 0);
    nw = ((b % BC) + l - 1) / BC + 1;
    check("reads_per_word", rd_cnt, nw);
    check("writes_per_word", wr_cnt, nw);
    check("max_outstanding_ok", max_out <= 4, 1'b1);
  endtask

  typedef struct {
    int base; int len; int preset; bit rnd;
    int n; int fa; logic [7:0] fbe; int la; logic [7:0] lbe;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [63:0] w0;
    int n, act;
    vecs[0] = '{base: 3,    len: 2,  preset: 1, rnd: 1'b0, n: 1, fa: 0,    fbe: 8'h18, la: 0, lbe: 8'h18};
    vecs[1] = '{base: 0,    len: 24, preset: 2, rnd: 1'b0, n: 3, fa: 0,    fbe: 8'hFF, la: 2, lbe: 8'hFF};
    // Window ends at byte 24, i.e. lane 0 of word 3.
    vecs[2] = '{base: 5,    len: 20, preset: 0, rnd: 1'b1, n: 4, fa: 0,    fbe: 8'hE0, la: 3, lbe: 8'h01};
    vecs[3] = '{base: 8188, len: 8,  preset: 0, rnd: 1'b0, n: 2, fa: 1023, fbe: 8'hF0, la: 0, lbe: 8'h0F};

    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
    srst = 1'b1; run = 1'b0; base_addr = '0; length = '0;
    run1 = 1'b0; base1 = '0; len1 = '0;
    repeat (3) @(negedge clk);
    check("rst_waitrequest", waitreq, 1'b0);
    check("rst_rd_read", rd_read, 1'b0);
    check("rst_wr_write", wr_write, 1'b0);
    check("rst_rd_addr", rd_addr, '0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_wr_be", wr_be, '0);
    srst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].preset == 1) begin
        w0 = 64'h00FF_0102_0304_0506;
        for (int j = 0; j < BC; j++) mem[j] = w0[j*8 +: 8];
      end else if (vecs[i].preset == 2) begin
        for (int j = 0; j < 24; j++) mem[j] = 8'hFF;
      end
      rnd_mode = vecs[i].rnd;
      do_run(vecs[i].base, vecs[i].len, 1'b0);
      check("vec_n_writes", wlog.size(), vecs[i].n);
      if (wlog.size() > 0) begin
        check("vec_first_addr", wlog[0].addr, vecs[i].fa);
        check("vec_first_be", wlog[0].be, vecs[i].fbe);
        check("vec_last_addr", wlog[wlog.size()-1].addr, vecs[i].la);
        check("vec_last_be", wlog[wlog.size()-1].be, vecs[i].lbe);
      end
      if (vecs[i].preset == 1) check("t1_word0", get_word(0), 64'h00FF_0103_0404_0506);
      if (vecs[i].preset == 2)
        for (int k = 0; k < 3; k++) check("wrap_ff_to_00", get_word(k), 64'h0);
    end
    rnd_mode = 1'b0;

    // Saturating instance over 24 bytes of 0xFF.
    n_wr1 = 0;
    @(negedge clk);
    base1 = '0; len1 = BA'(24); run1 = 1'b1;
    @(negedge clk);
    run1 = 1'b0;
    n = 0;
    while (waitreq1 && n < 500) begin @(negedge clk); n++; end
    check("sat_completes", waitreq1, 1'b0);
    check("sat_n_writes", n_wr1, 3);

    // Reset with three reads outstanding, then a fresh run.
    fixed_lat = 6;
    cur_base = 0; cur_len = 64;
    rd_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < NB; i++) snap[i] = mem[i];
    @(negedge clk);
    base_addr = '0; length = BA'(64); run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n = 0;
    while ((rd_cnt - wr_cnt) < 3 && n < 100) begin @(negedge clk); n++; end
    check("reached_3_outstanding", rd_cnt - wr_cnt, 3);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check("srst_drops_read", rd_read, 1'b0);
    check("srst_drops_write", wr_write, 1'b0);
    check("srst_idle", waitreq, 1'b0);
    forbid_wr = 1'b1;
    act = rd_cnt;
    repeat (20) @(negedge clk);
    forbid_wr = 1'b0;
    check("no_reads_after_reset", rd_cnt, act);
    check("stale_rsp_drained", pend.size(), 0);
    n = 0;
    for (int i = 0; i < NB; i++) if (mem[i] !== snap[i]) n++;
    check("mem_untouched_by_reset", n, 0);
    fixed_lat = 0;
    do_run(0, 16, 1'b0);

    // length 0 is ignored.
    act = 0;
    @(negedge clk);
    base_addr = BA'(40); length = '0; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (waitreq || rd_read || wr_write) act++;
      @(negedge clk);
    end
    check("len0_no_traffic", act, 0);

    // run while busy is ignored; the model still expects the first window.
    rnd_mode = 1'b1;
    do_run(100, 50, 1'b1);

    for (int r = 0; r < 6; r++) do_run(int'($urandom_range(0, NB-1)), int'($urandom_range(1, 80)), 1'b0);
    rnd_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
